// File: rtl/stream_capture_pkg.sv
// rtl/stream_capture_pkg.sv - shared state encoding and depth helper for stream_capture
// Contents:
//   state_e  : capture FSM states (IDLE, CAPTURE, DROP, DONE)
//   depth_of : number of samples addressable with a given address width
package stream_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DROP    = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/stream_capture_ram.sv
// rtl/stream_capture_ram.sv - simple dual-port capture memory, read-first, no reset
// Ports:
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address, sampled every cycle
//   rd_data_o  : registered read data (1-cycle latency, old data on same-address write)
module stream_capture_ram
  import stream_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Single clocked process with no reset so synthesis maps this onto block RAM.
  // The read samples the array before the write lands, giving read-first behaviour.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/stream_capture.sv
// rtl/stream_capture.sv - stream sink capturing one tlast-terminated frame per arm edge
// Ports:
//   clk, resetn                    : clock, asynchronous active-low reset
//   arm                            : rising edge starts a capture
//   s_tdata/s_tvalid/s_tready/s_tlast : input sample stream
//   rd_addr, rd_data               : synchronous read port into captured frame
//   done, done_pulse               : frame-captured level and entry pulse
//   overflow                       : frame was longer than memory depth
//   frame_len                      : samples stored (1..DEPTH)
//   beat_count                     : all beats accepted, including discarded ones
module stream_capture
  import stream_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  done_pulse,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   frame_len,
  output logic [31:0]           beat_count
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] FULL_LEN = (ADDR_WIDTH+1)'(DEPTH);

  state_e              state_q, state_d;
  logic                arm_q;
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] frame_len_q, frame_len_d;
  logic [31:0]         beat_count_q, beat_count_d;
  logic                overflow_q, overflow_d;
  logic                done_pulse_q;

  logic arm_edge;
  logic beat;
  logic wr_en;

  assign arm_edge = arm & ~arm_q;
  // Ready depends on state only, so upstream never sees a valid->ready loop.
  assign s_tready = (state_q == CAPTURE) || (state_q == DROP);
  assign beat     = s_tvalid & s_tready;
  assign wr_en    = (state_q == CAPTURE) & beat;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    frame_len_d  = frame_len_q;
    beat_count_d = beat_count_q;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (arm_edge) begin
          state_d      = CAPTURE;
          wr_ptr_d     = '0;
          frame_len_d  = '0;
          beat_count_d = '0;
          overflow_d   = 1'b0;
        end
      end
      CAPTURE: begin
        if (beat) begin
          wr_ptr_d     = wr_ptr_q + 1'b1;
          beat_count_d = beat_count_q + 32'd1;
          // tlast wins over the full check: a frame of exactly DEPTH is not an overflow.
          if (s_tlast) begin
            state_d     = DONE;
            frame_len_d = wr_ptr_q + 1'b1;
          end else if (wr_ptr_q == LAST_PTR) begin
            state_d    = DROP;
            overflow_d = 1'b1;
          end
        end
      end
      DROP: begin
        if (beat) begin
          beat_count_d = beat_count_q + 32'd1;
          if (s_tlast) begin
            state_d     = DONE;
            frame_len_d = FULL_LEN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      arm_q        <= 1'b0;
      wr_ptr_q     <= '0;
      frame_len_q  <= '0;
      beat_count_q <= '0;
      overflow_q   <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      arm_q        <= arm;
      wr_ptr_q     <= wr_ptr_d;
      frame_len_q  <= frame_len_d;
      beat_count_q <= beat_count_d;
      overflow_q   <= overflow_d;
      done_pulse_q <= (state_d == DONE) && (state_q != DONE);
    end
  end

  assign done       = (state_q == DONE);
  assign done_pulse = done_pulse_q;
  assign overflow   = overflow_q;
  assign frame_len  = frame_len_q;
  assign beat_count = beat_count_q;

  stream_capture_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (s_tdata),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

endmodule

// File: tb/tb_stream_capture.sv
// tb/tb_stream_capture.sv - scoreboard bench for stream_capture (DATA_WIDTH=16, ADDR_WIDTH=4)
module tb_stream_capture;

  localparam int DW = 16;
  localparam int AW = 4;

  typedef struct {
    int     len;
    int     beats;
    bit     ovf;
    longint cyc;
  } status_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          arm = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          done_pulse;
  logic          overflow;
  logic [AW:0]   frame_len;
  logic [31:0]   beat_count;

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;

  logic          rd_issue = 1'b0;
  logic          rd_pend = 1'b0;
  logic          pulse_prev = 1'b0;
  logic [DW-1:0] rd_exp_q[$];
  status_t       st_exp_q[$];

  stream_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .arm        (arm),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .done       (done),
    .done_pulse (done_pulse),
    .overflow   (overflow),
    .frame_len  (frame_len),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_issue;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents read data or a done pulse.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_exp_q.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(rd_exp_q.pop_front()));
      end
    end
    if (done_pulse) begin
      chk("done_pulse_width", 32'(pulse_prev), 32'd0);
      if (st_exp_q.size() == 0) begin
        chk("status_unexpected", 32'd1, 32'd0);
      end else begin
        status_t e;
        e = st_exp_q.pop_front();
        chk("done_latency", 32'(cyc), 32'(e.cyc));
        chk("done_level", 32'(done), 32'd1);
        chk("frame_len", 32'(frame_len), 32'(e.len));
        chk("beat_count", beat_count, 32'(e.beats));
        chk("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
    pulse_prev <= done_pulse;
  end

  task automatic pulse_arm();
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
  endtask

  // Sends n beats of base+i; gappy uses a 1,0,0,1 valid pattern. arm_at>=0 raises arm
  // for one cycle at that cycle index to exercise mid-capture re-arm.
  task automatic send_frame(input int n, input logic [DW-1:0] base, input bit gappy,
                            input int exp_len, input bit exp_ovf, input int arm_at);
    int   sent = 0;
    int   k = 0;
    logic v;
    while (sent < n && k < 400) begin
      @(posedge clk); #1;
      v        = gappy ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
      arm      = (k == arm_at);
      s_tvalid = v;
      s_tdata  = base + DW'(sent);
      s_tlast  = (sent == n - 1);
      k++;
      @(negedge clk);
      if (v && s_tready) begin
        if (sent == n - 1) begin
          status_t e;
          e.len = exp_len; e.beats = n; e.ovf = exp_ovf; e.cyc = cyc + 1;
          st_exp_q.push_back(e);
        end
        sent++;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    arm      = 1'b0;
    chk("frame_sent", 32'(sent), 32'(n));
    if (!gappy) chk("ready_no_stall", 32'(k), 32'(n));
  endtask

  task automatic read_frame(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_addr  = AW'(i);
      rd_issue = 1'b1;
      rd_exp_q.push_back(base + DW'(i));
    end
    @(posedge clk); #1 rd_issue = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_pulse", 32'(done_pulse), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_len", 32'(frame_len), 32'd0);
    chk("rst_beat_count", beat_count, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // Basic 8-beat frame
    pulse_arm();
    send_frame(8, 16'h0100, 1'b0, 8, 1'b0, -1);
    read_frame(8, 16'h0100);

    // Gappy valid, 5 beats
    pulse_arm();
    send_frame(5, 16'h0200, 1'b1, 5, 1'b0, -1);
    read_frame(5, 16'h0200);

    // Exact fill
    pulse_arm();
    send_frame(16, 16'h0300, 1'b0, 16, 1'b0, -1);
    read_frame(16, 16'h0300);

    // Overflow: 20 beats, last 4 discarded
    pulse_arm();
    send_frame(20, 16'h0400, 1'b0, 16, 1'b1, -1);
    read_frame(16, 16'h0400);

    // Backpressure in DONE
    rdy_cnt = 0;
    @(posedge clk); #1 s_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_tready) rdy_cnt++;
    end
    chk("done_backpressure", 32'(rdy_cnt), 32'd0);
    chk("done_held", 32'(done), 32'd1);
    chk("beats_frozen", beat_count, 32'd20);
    @(posedge clk); #1 s_tvalid = 1'b0;

    // Fresh arm clears status
    pulse_arm();
    @(negedge clk);
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_overflow", 32'(overflow), 32'd0);
    chk("rearm_beats", beat_count, 32'd0);
    chk("rearm_len", 32'(frame_len), 32'd0);
    chk("rearm_tready", 32'(s_tready), 32'd1);

    // Arm re-pulsed mid-capture is ignored
    send_frame(6, 16'h0500, 1'b0, 6, 1'b0, 2);
    read_frame(6, 16'h0500);

    // Reset mid-capture after 3 beats
    pulse_arm();
    @(posedge clk); #1;
    s_tvalid = 1'b1;
    s_tdata  = 16'h0600;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_tready", 32'(s_tready), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_beats", beat_count, 32'd0);
    s_tvalid = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_idle_tready", 32'(s_tready), 32'd0);
    chk("postrst_done", 32'(done), 32'd0);
    chk("postrst_overflow", 32'(overflow), 32'd0);
    chk("postrst_len", 32'(frame_len), 32'd0);
    chk("postrst_beats", beat_count, 32'd0);

    pulse_arm();
    send_frame(4, 16'h0700, 1'b0, 4, 1'b0, -1);
    read_frame(4, 16'h0700);

    for (int i = 0; i < 10 && (rd_exp_q.size() != 0 || st_exp_q.size() != 0); i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    chk("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
    chk("status_queue_drained", 32'(st_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_capture.md
Name: stream_capture

Overview:
- AXI-Stream sink that captures one tlast-terminated frame into on-chip memory on an arm edge.
- Sits downstream of the triggered frame gater, which produces N-sample frames with tlast on the final beat.
- Exposes the captured frame to software or a bus bridge through a synchronous random-access read port, plus status (done, length, overflow, beat count).

Parameters:
DATA_WIDTH, 16, sample width in bits
ADDR_WIDTH, 10, log2 of capture depth; DEPTH = 2**ADDR_WIDTH samples

Ports:
clk  in  1  single clock; all logic on rising edge
resetn  in  1  asynchronous, active-low reset
arm  in  1  rising edge starts a capture
s_tdata  in  DATA_WIDTH  stream sample
s_tvalid  in  1  stream valid
s_tready  out  1  stream ready
s_tlast  in  1  last beat of frame
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  memory word at rd_addr, 1-cycle latency
done  out  1  level; frame captured, cleared on next accepted arm
done_pulse  out  1  one-cycle pulse on entry to DONE
overflow  out  1  frame exceeded DEPTH; valid while done=1
frame_len  out  ADDR_WIDTH+1  samples stored (1..DEPTH)
beat_count  out  32  all beats accepted in the frame, including discarded ones; wraps modulo 2**32

Behaviour:
- Reset (asynchronous assert, synchronous to clk on release):
  - state=IDLE; s_tready, done, done_pulse, overflow = 0; frame_len, beat_count, wr_ptr = 0.
  - arm edge register = 0.
  - Memory contents are not reset. rd_data after reset is undefined until the first read cycle.
- Arm detection: arm_edge = arm & ~arm_q, with arm_q registered every cycle.
- States:
  - IDLE: s_tready=0. On arm_edge -> CAPTURE; clear wr_ptr, beat_count, frame_len, overflow, done.
  - CAPTURE: s_tready=1 (combinational from state only; never depends on s_tvalid). On each beat (s_tvalid & s_tready):
    - Write s_tdata to mem[wr_ptr]; wr_ptr++; beat_count++.
    - If s_tlast: -> DONE; frame_len = wr_ptr+1.
    - Else if wr_ptr == DEPTH-1: -> DROP; overflow <= 1.
  - DROP: s_tready=1. Each beat increments beat_count with no write. On a beat with s_tlast: -> DONE; frame_len = DEPTH.
  - DONE: s_tready=0, done=1. done_pulse is high on the first cycle in DONE only. On arm_edge -> CAPTURE with all clears as from IDLE.
- Beat with s_tlast exactly at wr_ptr == DEPTH-1: -> DONE, frame_len = DEPTH, overflow = 0.
- arm_edge in CAPTURE or DROP is ignored; the capture continues.
- arm held high does not re-arm; a new rising edge is required.
- A beat in IDLE/DONE is impossible, since s_tready=0; upstream stalls.
- Read port: rd_data <= mem[rd_addr] every cycle, in any state.
  - Same-address read during a write returns the old data (read-first).
  - Software must read only after done=1.
- Width rules:
  - frame_len is ADDR_WIDTH+1 bits so it can hold DEPTH.
  - wr_ptr is ADDR_WIDTH+1 bits; its MSB is never set in CAPTURE.
- Reset mid-capture: immediate return to IDLE, all status cleared. Upstream sees s_tready drop asynchronously.
- Latency: a sample accepted in cycle t is readable with rd_addr set in cycle t+1, data valid at t+2. done rises on the cycle after the tlast beat.

Decomposition:
- Package stream_capture_pkg holds:
  - State encoding constants: IDLE=2'd0, CAPTURE=2'd1, DROP=2'd2, DONE=2'd3.
  - Helper constant for DEPTH derived from ADDR_WIDTH.
- One sub-module: stream_capture_ram, a simple dual-port RAM.
  - One write port, one synchronous read port, read-first, no reset, parameterised by DATA_WIDTH/ADDR_WIDTH.
  - Written so it infers block RAM.

Test Plan:
- Bench parameters: DATA_WIDTH=16, ADDR_WIDTH=4 (DEPTH=16).
- Basic frame: reset, pulse arm, send 8 beats with data 0x100..0x107 and tlast on the 8th, tvalid always high -> done=1 one cycle after the last beat, done_pulse 1 cycle, frame_len=8, beat_count=8, overflow=0, rd_addr 0..7 returns 0x100..0x107.
- Gappy valid: 5-beat frame with tvalid toggling 1,0,0,1 pattern -> frame_len=5, beat_count=5, data stored in order with no duplicates.
- Exact fill: 16-beat frame, tlast on beat 16 -> frame_len=16, overflow=0.
- Overflow: 20-beat frame -> state passes through DROP, s_tready stays 1 until tlast, frame_len=16, beat_count=20, overflow=1, mem[15]=beat 16 data.
- Arm handling and backpressure:
  - Arm re-pulsed mid-capture is ignored; frame completes normally.
  - In DONE, s_tvalid=1 sees s_tready=0 for 50 cycles.
  - A fresh arm clears done/overflow and captures the next frame from address 0.
- Reset mid-capture: assert resetn=0 after 3 beats -> s_tready=0 and done=0 immediately; after release, status is all zero and state is IDLE until the next arm edge.
